aes_uart_host: RTL

AES_UART_HOST -- requirements
Module: aes_uart_host

---
 rtl/aes_uart_host.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/aes_uart_host.sv
`default_nettype none
// ============================================================================
// aes_uart_host : streams key+plaintext to a UART AES core, collects the reply
// Rev 1.0
// ============================================================================
module aes_uart_host #(
    parameter logic [27:0] CLOCK_FREQ   = 28'd50000000,
    parameter logic [23:0] BAUD_RATE    = 24'd4000000,
    parameter int          TX_GAP       = 16,
    parameter int          RESP_TIMEOUT = 20000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    input  logic         uart_rx,
    output logic         uart_tx,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic [4:0]   bytes_rcvd,
    output logic         timeout_err,
    output logic         frame_err
);
    localparam int CLKS_PER_BIT = int'(32'(CLOCK_FREQ) / 32'(BAUD_RATE));
    localparam int TO_W         = $clog2(RESP_TIMEOUT + 1);
    localparam logic [15:0]     BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]     HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]     GAP_LAST  = 16'(TX_GAP - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND, GAP, RECV, FINISH} state_t;
    state_t state, next_state;

    logic [255:0]    tx_data;
    logic [4:0]      tx_byte;
    logic [3:0]      tx_bit;
    logic [15:0]     tx_cnt;
    logic [7:0]      cur_byte;
    logic            tx_next;
    logic            accept, bit_end, byte_end, gap_end, timeout_hit;
    logic            rx_meta, rx_sync, rx_prev, rx_active;
    logic [3:0]      rx_bit;
    logic [15:0]     rx_cnt;
    logic [7:0]      rx_shift;
    logic [TO_W-1:0] to_cnt;

    assign accept      = (state == IDLE) && start;
    assign cur_byte    = tx_data[{tx_byte, 3'b000} +: 8];
    assign bit_end     = (tx_cnt == BIT_LAST);
    assign byte_end    = bit_end && (tx_bit == 4'd9);
    assign gap_end     = (tx_cnt == GAP_LAST);
    assign timeout_hit = (to_cnt == TO_LAST);
    assign busy        = (state == SEND) || (state == GAP) || (state == RECV);
    assign done        = (state == FINISH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        tx_next    = 1'b1;
        case (state)
            IDLE: if (start) next_state = SEND;
            SEND: begin
                // tx_bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit
                case (tx_bit)
                    4'd0:    tx_next = 1'b0;
                    4'd9:    tx_next = 1'b1;
                    default: tx_next = cur_byte[3'(tx_bit - 4'd1)];
                endcase
                if (byte_end) next_state = (tx_byte == 5'd31) ? RECV : GAP;
            end
            GAP:     if (gap_end) next_state = SEND;
            RECV:    if ((bytes_rcvd == 5'd16) || timeout_hit) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data <= '0;
            tx_byte <= '0;
            tx_bit  <= '0;
            tx_cnt  <= '0;
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= tx_next;
            if (accept) begin
                tx_data <= {plaintext, key};
                tx_byte <= '0;
                tx_bit  <= '0;
                tx_cnt  <= '0;
            end else if (state == SEND) begin
                if (bit_end) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_bit  <= '0;
                        tx_byte <= tx_byte + 5'd1;
                    end else begin
                        tx_bit <= tx_bit + 4'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 16'd1;
                end
            end else if (state == GAP) begin
                tx_cnt <= gap_end ? 16'd0 : tx_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            rx_active   <= 1'b0;
            rx_bit      <= '0;
            rx_cnt      <= '0;
            rx_shift    <= '0;
            to_cnt      <= '0;
            ciphertext  <= '0;
            bytes_rcvd  <= '0;
            timeout_err <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (accept) begin
                ciphertext  <= '0;
                bytes_rcvd  <= '0;
                timeout_err <= 1'b0;
                frame_err   <= 1'b0;
                rx_active   <= 1'b0;
                to_cnt      <= '0;
            end else if (state != RECV) begin
                rx_active <= 1'b0;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
                if (timeout_hit) timeout_err <= 1'b1;
                if (!rx_active) begin
                    if (rx_prev && !rx_sync) begin
                        rx_active <= 1'b1;
                        rx_bit    <= '0;
                        rx_cnt    <= '0;
                    end
                end else if (rx_bit == 4'd0) begin
                    // mid-start-bit check; a high line here means a glitch
                    if (rx_cnt == HALF_LAST) begin
                        if (rx_sync) begin
                            rx_active <= 1'b0;
                        end else begin
                            rx_bit <= 4'd1;
                            rx_cnt <= '0;
                            to_cnt <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end else if (rx_cnt == BIT_LAST) begin
                    rx_cnt <= '0;
                    if (rx_bit == 4'd9) begin
                        rx_active <= 1'b0;
                        if (rx_sync) begin
                            ciphertext[{bytes_rcvd[3:0], 3'b000} +: 8] <= rx_shift;
                            bytes_rcvd <= bytes_rcvd + 5'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 4'd1;
                    end
                end else begin
                    rx_cnt <= rx_cnt + 16'd1;
                end
            end
        end
    end
endmodule
`default_nettype wire
